stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 15 +
 rtl/stack_ram.sv | 25 ++
 rtl/stack_unit.sv | 156 +++++++++++++++
 tb/tb_stack_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared defaults and operation encoding for the hardware stack.
package stack_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefAddrW = 9;

   // Encoding is {pop, psh}, so the raw request pair maps directly onto it.
   typedef enum logic [1:0] {
      OpNop  = 2'b00,
      OpPush = 2'b01,
      OpPop  = 2'b10,
      OpRepl = 2'b11
   } op_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: register array with one synchronous write port and one
// combinational read port. Contents are never reset.
module stack_ram #(
   parameter int unsigned DATA_W = stack_pkg::DefDataW,
   parameter int unsigned ADDR_W = stack_pkg::DefAddrW
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Empty-descending hardware stack with registered top-of-stack, entry count
// and sticky overflow/underflow flags.
module stack_unit
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned ADDR_W   = DefAddrW,
   parameter int unsigned DEPTH    = 2**ADDR_W,
   parameter int unsigned SP_RESET = 2**ADDR_W - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psh,
   input  logic              pop,
   input  logic              clr,
   input  logic              err_clr,
   input  logic [DATA_W-1:0] din,
   output logic [ADDR_W-1:0] sp,
   output logic [DATA_W-1:0] tos,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              udf
);

   localparam int unsigned CntW = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] SpInit = ADDR_W'(SP_RESET);
   localparam logic [ADDR_W-1:0] SpOne  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] SpTwo  = ADDR_W'(2);
   localparam logic [CntW-1:0]   CntOne = CntW'(1);
   localparam logic [CntW-1:0]   CntMax = CntW'(DEPTH);

   logic [ADDR_W-1:0] sp_q, sp_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [DATA_W-1:0] tos_q, tos_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic              is_empty, is_full;
   logic              do_push, do_pop, do_repl;
   logic              ovf_evt, udf_evt;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;
   op_e               op;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CntMax);
   assign op       = op_e'({pop, psh});

   // Resolve the raw request into exactly one action; clr overrides all.
   always_comb begin
      do_push = 1'b0;
      do_pop  = 1'b0;
      do_repl = 1'b0;
      ovf_evt = 1'b0;
      udf_evt = 1'b0;
      if (!clr) begin
         unique case (op)
            OpNop: ;
            OpPush: begin
               if (is_full) begin
                  ovf_evt = 1'b1;
               end else begin
                  do_push = 1'b1;
               end
            end
            OpPop: begin
               if (is_empty) begin
                  udf_evt = 1'b1;
               end else begin
                  do_pop = 1'b1;
               end
            end
            OpRepl: begin
               if (is_empty) begin
                  do_push = 1'b1;
               end else begin
                  do_repl = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Push writes the free slot at sp; replace rewrites the top at sp+1.
   // A pop needs the word below the current top, which sits at sp+2.
   assign ram_we    = do_push | do_repl;
   assign ram_waddr = do_repl ? (sp_q + SpOne) : sp_q;
   assign ram_raddr = sp_q + SpTwo;

   always_comb begin
      sp_d    = sp_q;
      count_d = count_q;
      tos_d   = tos_q;
      if (clr) begin
         sp_d    = SpInit;
         count_d = '0;
         tos_d   = '0;
      end else if (do_push) begin
         sp_d    = sp_q - SpOne;
         count_d = count_q + CntOne;
         tos_d   = din;
      end else if (do_pop) begin
         sp_d    = sp_q + SpOne;
         count_d = count_q - CntOne;
         tos_d   = (count_q == CntOne) ? '0 : ram_rdata;
      end else if (do_repl) begin
         tos_d   = din;
      end
   end

   // Error events take precedence over a same-cycle err_clr.
   assign ovf_d = (ovf_q & ~err_clr) | ovf_evt;
   assign udf_d = (udf_q & ~err_clr) | udf_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q    <= SpInit;
         count_q <= '0;
         tos_q   <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         tos_q   <= tos_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   stack_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(din),
      .raddr(ram_raddr),
      .rdata(ram_rdata)
   );

   assign sp    = sp_q;
   assign tos   = tos_q;
   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign udf   = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with an 8-entry stack and hand-computed
// expected values.
module tb_stack_unit;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              psh = 1'b0;
   logic              pop = 1'b0;
   logic              clr = 1'b0;
   logic              err_clr = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic [ADDR_W-1:0] sp;
   logic [DATA_W-1:0] tos;
   logic [ADDR_W:0]   count;
   logic              empty, full, ovf, udf;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stack_unit #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (8),
      .SP_RESET(7)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .psh    (psh),
      .pop    (pop),
      .clr    (clr),
      .err_clr(err_clr),
      .din    (din),
      .sp     (sp),
      .tos    (tos),
      .count  (count),
      .empty  (empty),
      .full   (full),
      .ovf    (ovf),
      .udf    (udf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clocked operation; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic p, input logic q, input logic c, input logic e,
                       input logic [DATA_W-1:0] d);
      psh = p; pop = q; clr = c; err_clr = e; din = d;
      @(posedge clk);
      #1;
      psh = 1'b0; pop = 1'b0; clr = 1'b0; err_clr = 1'b0; din = '0;
   endtask

   task automatic chk_state(input string tag, input logic [ADDR_W-1:0] e_sp,
                            input logic [ADDR_W:0] e_cnt, input logic [DATA_W-1:0] e_tos);
      chk({tag, ".sp"}, 32'(sp), 32'(e_sp));
      chk({tag, ".count"}, 32'(count), 32'(e_cnt));
      chk({tag, ".tos"}, 32'(tos), 32'(e_tos));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_state("reset", 3'd7, 4'd0, 16'h0000);
      chk("reset.empty", 32'(empty), 32'd1);
      chk("reset.full", 32'(full), 32'd0);
      chk("reset.ovf", 32'(ovf), 32'd0);
      chk("reset.udf", 32'(udf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three pushes, one-cycle tos latency
      step(1, 0, 0, 0, 16'h1111);
      chk_state("push1", 3'd6, 4'd1, 16'h1111);
      step(1, 0, 0, 0, 16'h2222);
      step(1, 0, 0, 0, 16'h3333);
      chk_state("push3", 3'd4, 4'd3, 16'h3333);
      chk("push3.empty", 32'(empty), 32'd0);

      // Pop down to empty, then underflow
      step(0, 1, 0, 0, '0);
      chk_state("pop1", 3'd5, 4'd2, 16'h2222);
      step(0, 1, 0, 0, '0);
      chk_state("pop2", 3'd6, 4'd1, 16'h1111);
      step(0, 1, 0, 0, '0);
      chk_state("pop3", 3'd7, 4'd0, 16'h0000);
      chk("pop3.empty", 32'(empty), 32'd1);
      chk("pop3.udf", 32'(udf), 32'd0);
      step(0, 1, 0, 0, '0);
      chk_state("udf", 3'd7, 4'd0, 16'h0000);
      chk("udf.flag", 32'(udf), 32'd1);
      step(0, 0, 0, 1, '0);
      chk("udf.errclr", 32'(udf), 32'd0);

      // Replace on empty behaves as a push
      step(1, 1, 0, 0, 16'h1111);
      chk_state("repl_empty", 3'd6, 4'd1, 16'h1111);
      chk("repl_empty.udf", 32'(udf), 32'd0);
      chk("repl_empty.ovf", 32'(ovf), 32'd0);
      step(1, 0, 0, 0, 16'h2222);
      step(1, 1, 0, 0, 16'hABCD);
      chk_state("repl", 3'd5, 4'd2, 16'hABCD);
      step(0, 1, 0, 0, '0);
      chk_state("repl_pop", 3'd6, 4'd1, 16'h1111);

      // Clear, then fill all 8 entries and overflow
      step(0, 0, 1, 0, '0);
      chk_state("clr0", 3'd7, 4'd0, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 0, 0, 16'(i));
      end
      chk_state("fill", 3'd7, 4'd8, 16'h0008);
      chk("fill.full", 32'(full), 32'd1);
      step(1, 0, 0, 0, 16'h0009);
      chk_state("ovf", 3'd7, 4'd8, 16'h0008);
      chk("ovf.flag", 32'(ovf), 32'd1);
      chk("ovf.full", 32'(full), 32'd1);

      // Replace while full, then pop across the wrapped pointer
      step(1, 1, 0, 0, 16'hBEEF);
      chk_state("repl_full", 3'd7, 4'd8, 16'hBEEF);
      step(0, 1, 0, 0, '0);
      chk_state("pop_wrap", 3'd0, 4'd7, 16'h0007);
      chk("pop_wrap.full", 32'(full), 32'd0);
      step(1, 0, 0, 0, 16'h0008);
      chk_state("refill", 3'd7, 4'd8, 16'h0008);

      // Error event beats err_clr in the same cycle
      step(1, 0, 0, 1, 16'h0009);
      chk("errclr_race.ovf", 32'(ovf), 32'd1);
      step(0, 0, 0, 1, '0);
      chk("errclr.ovf", 32'(ovf), 32'd0);

      // Clear from 5 entries keeps sticky flags
      step(0, 0, 1, 0, '0);
      step(0, 1, 0, 0, '0);
      chk("udf2.flag", 32'(udf), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 16'h0010 + 16'(i));
      end
      chk_state("five", 3'd2, 4'd5, 16'h0014);
      step(0, 0, 1, 0, '0);
      chk_state("clr5", 3'd7, 4'd0, 16'h0000);
      chk("clr5.udf", 32'(udf), 32'd1);
      chk("clr5.ovf", 32'(ovf), 32'd0);

      // Asynchronous reset between edges with a push pending
      step(1, 0, 0, 0, 16'h7777);
      @(negedge clk);
      psh = 1'b1;
      din = 16'h8888;
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("arst", 3'd7, 4'd0, 16'h0000);
      chk("arst.udf", 32'(udf), 32'd0);
      chk("arst.empty", 32'(empty), 32'd1);
      @(posedge clk);
      #1;
      chk_state("arst_hold", 3'd7, 4'd0, 16'h0000);
      psh = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      step(1, 0, 0, 0, 16'h5555);
      chk_state("post_rst", 3'd6, 4'd1, 16'h5555);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
